// File: rtl/sram_controller.sv
// sram_controller: bridges 32-bit word load/store requests from the MEM stage to a
// 16-bit asynchronous SRAM. Each access runs two 16-bit SRAM cycles (low half first),
// then a fixed settle time. 'ready' stays low until the access completes.
// Optional feature macro: SRAM_READ_HIT_EN. When defined, a read of the word that was
// last read completes in one cycle and issues no SRAM cycles.
module sram_controller #(
    parameter int ADDR_BASE   = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    inout  wire  [15:0] SRAM_DQ,
    output logic [17:0] SRAM_ADDR,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_WE_N
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOW  = 3'd1;
    localparam logic [2:0] S_HIGH = 3'd2;
    localparam logic [2:0] S_WAIT = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    logic [2:0]       state;
    logic             op_write;
    logic [16:0]      word_addr;
    logic [31:0]      wdata;
    logic [CNT_W-1:0] wait_cnt;
    logic [15:0]      dq_out;
    logic             tag_match;

    // Word index of the incoming request. Only 17 bits reach the SRAM, so higher
    // address bits alias onto the same SRAM word.
    logic [31:0] offset;
    logic [16:0] req_key;
    logic        unused_offset_bits;
    assign offset             = address - 32'(ADDR_BASE);
    assign req_key            = offset[18:2];
    assign unused_offset_bits = ^{offset[31:19], offset[1:0]};

`ifdef SRAM_READ_HIT_EN
    logic [31:0] tag;
    logic        tag_valid;

    // Tag is kept in the same 17-bit key space as the SRAM so aliased writes invalidate it.
    assign tag_match = tag_valid && (tag == {15'd0, req_key});

    // Track the word of the last completed SRAM read; any write to it invalidates the tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag       <= '0;
            tag_valid <= 1'b0;
        end else if (state == S_IDLE && wr_en && tag_match) begin
            tag_valid <= 1'b0;
        end else if (state == S_HIGH && !op_write) begin
            tag       <= {15'd0, word_addr};
            tag_valid <= 1'b1;
        end
    end
`else
    assign tag_match = 1'b0;
`endif

    // Access sequencer: latch the request, run both halves, settle, then signal done.
    // NOTE: all state here uses <= so every register samples pre-edge values; blocking
    // assignments would make the read capture and state update order-dependent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            op_write  <= 1'b0;
            word_addr <= '0;
            wdata     <= '0;
            wait_cnt  <= '0;
            read_data <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (wr_en || rd_en) begin
                        op_write  <= wr_en;
                        word_addr <= req_key;
                        wdata     <= write_data;
                        wait_cnt  <= '0;
                        state     <= (!wr_en && tag_match) ? S_DONE : S_LOW;
                    end
                end
                S_LOW: begin
                    if (!op_write) read_data[15:0] <= SRAM_DQ;
                    state <= S_HIGH;
                end
                S_HIGH: begin
                    if (!op_write) read_data[31:16] <= SRAM_DQ;
                    state <= (WAIT_CYCLES == 0) ? S_DONE : S_WAIT;
                end
                S_WAIT: begin
                    if (wait_cnt == CNT_W'(WAIT_CYCLES - 1)) begin
                        wait_cnt <= '0;
                        state    <= S_DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // SRAM pin drive derived from the current state and the latched request.
    // NOTE: every output gets a default first so no path through the block infers a latch.
    always_comb begin
        SRAM_ADDR = {word_addr, 1'b0};
        dq_out    = wdata[15:0];
        SRAM_WE_N = 1'b1;
        if (state == S_HIGH) begin
            SRAM_ADDR = {word_addr, 1'b1};
            dq_out    = wdata[31:16];
        end
        if (op_write && (state == S_LOW || state == S_HIGH)) SRAM_WE_N = 1'b0;
    end

    assign SRAM_DQ   = SRAM_WE_N ? 16'bz : dq_out;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_OE_N = 1'b0;

    // Drops combinationally in the cycle a request appears so the pipeline freezes at once.
    assign ready = ((state == S_IDLE) && !rd_en && !wr_en) || (state == S_DONE);

endmodule
